// File: rtl/cnn_pkg.sv
// cnn_pkg: shared fixed-point widths and the floor-shift/saturate used by every MAC lane.
// Pure combinational helpers; no latency, no flow control.
package cnn_pkg;

    localparam int BITS      = 16;
    localparam int FRAC_BITS = 8;

    // 4 guard bits cover a 3x3 window (9 products) without overflow.
    function automatic int acc_bits(input int bits);
        return 2 * bits + 4;
    endfunction

    localparam int ACC_BITS = acc_bits(BITS);

    // Arithmetic shift (floor) then clamp into a signed 'bits'-wide range.
    function automatic logic signed [63:0] shift_sat(
        input logic signed [63:0] acc,
        input int                 bits,
        input int                 frac
    );
        logic signed [63:0] sh;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sh    = acc >>> frac;
        max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (bits - 1));
        if (sh > max_v) begin
            return max_v;
        end else if (sh < min_v) begin
            return min_v;
        end
        return sh;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one pixel x kernel multiply / accumulate / shift-saturate lane.
// Product, accumulator and result registers driven by enables from the array control.
module conv_mac_lane #(
    parameter int BITS      = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            mul_en,
    input  logic            acc_en,
    input  logic            acc_load,
    input  logic            out_en,
    input  logic [BITS-1:0] pix,
    input  logic [BITS-1:0] wgt,
    output logic [BITS-1:0] res
);
    import cnn_pkg::*;

    localparam int PROD_W = 2 * BITS;
    localparam int ACC_W  = acc_bits(BITS);

    logic signed [PROD_W-1:0] pix_x;
    logic signed [PROD_W-1:0] wgt_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  acc;
    logic signed [63:0]       sat;
    logic [BITS-1:0]          res_nxt;

    assign pix_x  = PROD_W'(signed'(pix));
    assign wgt_x  = PROD_W'(signed'(wgt));
    assign prod_x = ACC_W'(prod);

    always_comb begin
        sat     = shift_sat(64'(acc), BITS, FRAC_BITS);
        res_nxt = BITS'(sat);
`ifdef CONV1_RELU_EN
        if (sat < 64'sd0) begin
            res_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
            acc  <= '0;
            res  <= '0;
        end else begin
            if (mul_en) begin
                prod <= pix_x * wgt_x;
            end
            if (acc_en) begin
                acc <= acc_load ? prod_x : acc + prod_x;
            end
            if (out_en) begin
                res <= res_nxt;
            end
        end
    end

endmodule

// File: rtl/conv1_mac_array.sv
// conv1_mac_array: PAR_NUM x CONV_NUM 3x3 conv MAC array; CONV1_RELU_EN clamps negative results to 0.
// out_valid 2 edges after the last tap; no backpressure, in_valid may be held every cycle.
module conv1_mac_array #(
    parameter int BITS       = cnn_pkg::BITS,
    parameter int FRAC_BITS  = cnn_pkg::FRAC_BITS,
    parameter int PAR_NUM    = 16,
    parameter int CONV_NUM   = 4,
    parameter int WEIGHT_NUM = 9,
    parameter int WIN_NUM    = 225
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             in_valid,
    input  logic [PAR_NUM*BITS-1:0]          map,
    input  logic [CONV_NUM*BITS-1:0]         weight,
    output logic                             out_valid,
    output logic [PAR_NUM*CONV_NUM*BITS-1:0] out_data,
    output logic                             frame_done
);
    import cnn_pkg::*;

    localparam int TAP_W = $clog2(WEIGHT_NUM);
    localparam int WIN_W = $clog2(WIN_NUM);

    logic [TAP_W-1:0] tap_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic             s1_vld;
    logic             s1_first;
    logic             s1_last;
    logic             s2_last;
    logic             mul_en;
    logic             acc_en;
    logic             out_en;
    logic             tap_is_last;
    logic             win_is_last;

    assign tap_is_last = (tap_cnt == TAP_W'(WEIGHT_NUM - 1));
    assign win_is_last = (win_cnt == WIN_W'(WIN_NUM - 1));
    // clr freezes the datapath in the same cycle so an aborted window leaves out_data untouched.
    assign mul_en      = in_valid & ~clr;
    assign acc_en      = s1_vld & ~clr;
    assign out_en      = s2_last & ~clr;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt    <= '0;
            win_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s2_last    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (clr) begin
            tap_cnt    <= '0;
            win_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s2_last    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s1_vld     <= in_valid;
            s1_first   <= (tap_cnt == '0);
            s1_last    <= tap_is_last;
            s2_last    <= s1_vld & s1_last;
            out_valid  <= s2_last;
            frame_done <= s2_last & win_is_last;
            if (in_valid) begin
                tap_cnt <= tap_is_last ? '0 : tap_cnt + 1'b1;
            end
            if (s2_last) begin
                win_cnt <= win_is_last ? '0 : win_cnt + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CONV_NUM; c++) begin : g_conv
        for (genvar p = 0; p < PAR_NUM; p++) begin : g_par
            conv_mac_lane #(
                .BITS      (BITS),
                .FRAC_BITS (FRAC_BITS)
            ) u_lane (
                .clk_in   (clk_in),
                .rst_n    (rst_n),
                .mul_en   (mul_en),
                .acc_en   (acc_en),
                .acc_load (s1_first),
                .out_en   (out_en),
                .pix      (map[p*BITS +: BITS]),
                .wgt      (weight[c*BITS +: BITS]),
                .res      (out_data[(c*PAR_NUM+p)*BITS +: BITS])
            );
        end
    end

endmodule

// File: tb/tb_conv1_mac_array.sv
// Bench for conv1_mac_array: directed corner windows plus random windows against a sum-of-products model.
module tb_conv1_mac_array;

    localparam int BITS  = 16;
    localparam int FRAC  = 8;
    localparam int PAR   = 16;
    localparam int CONV  = 4;
    localparam int TAPS  = 9;
    localparam int WINS  = 225;
    localparam int OUT_W = PAR * CONV * BITS;

    logic                 clk_in   = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 clr      = 1'b0;
    logic                 in_valid = 1'b0;
    logic [PAR*BITS-1:0]  map      = '0;
    logic [CONV*BITS-1:0] weight   = '0;
    logic                 out_valid;
    logic                 frame_done;
    logic [OUT_W-1:0]     out_data;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    longint ov_cyc = 0;
    longint last_tap_cyc = 0;
    int     ov_cnt = 0;
    int     fd_cnt = 0;
    int     fd_idx = 0;
    logic [OUT_W-1:0] ov_q[$];

    logic [BITS-1:0]  pix_tab[TAPS][PAR];
    logic [BITS-1:0]  wt_tab[TAPS][CONV];
    logic [OUT_W-1:0] exp_data;

    conv1_mac_array #(
        .BITS       (BITS),
        .FRAC_BITS  (FRAC),
        .PAR_NUM    (PAR),
        .CONV_NUM   (CONV),
        .WEIGHT_NUM (TAPS),
        .WIN_NUM    (WINS)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .map        (map),
        .weight     (weight),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (out_valid) begin
            ov_cnt++;
            ov_cyc = cyc;
            ov_q.push_back(out_data);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_idx = ov_cnt;
        end
    end

    function automatic void fill_const(input logic [BITS-1:0] pv, input logic [BITS-1:0] wv);
        for (int t = 0; t < TAPS; t++) begin
            for (int p = 0; p < PAR; p++) pix_tab[t][p] = pv;
            for (int c = 0; c < CONV; c++) wt_tab[t][c] = wv;
        end
    endfunction

    // wide=0 keeps operands small enough that sums never saturate.
    function automatic void fill_random(input bit wide);
        for (int t = 0; t < TAPS; t++) begin
            for (int p = 0; p < PAR; p++)
                pix_tab[t][p] = wide ? BITS'($urandom) : BITS'($urandom_range(0, 1023) - 512);
            for (int c = 0; c < CONV; c++)
                wt_tab[t][c] = wide ? BITS'($urandom) : BITS'($urandom_range(0, 1023) - 512);
        end
    endfunction

    // Reference: exact dot product over the window, floor by 2^FRAC, clamp.
    function automatic void compute_model();
        longint s;
        longint max_v;
        longint min_v;
        max_v = (longint'(1) <<< (BITS - 1)) - 1;
        min_v = -(longint'(1) <<< (BITS - 1));
        for (int c = 0; c < CONV; c++) begin
            for (int p = 0; p < PAR; p++) begin
                s = 0;
                for (int t = 0; t < TAPS; t++)
                    s += longint'($signed(pix_tab[t][p])) * longint'($signed(wt_tab[t][c]));
                s = s >>> FRAC;
                if (s > max_v) s = max_v;
                if (s < min_v) s = min_v;
`ifdef CONV1_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_data[(c*PAR+p)*BITS +: BITS] = BITS'(s);
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic put_tap(input int t);
        for (int p = 0; p < PAR; p++) map[p*BITS +: BITS] = pix_tab[t][p];
        for (int c = 0; c < CONV; c++) weight[c*BITS +: BITS] = wt_tab[t][c];
        in_valid = 1'b1;
    endtask

    task automatic drive_taps(input int first, input int last, input int gap);
        for (int t = first; t <= last; t++) begin
            put_tap(t);
            @(posedge clk_in);
            #1;
            last_tap_cyc = cyc;
            in_valid = 1'b0;
            idle(gap);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk_in);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        tests++;
        if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        repeat (2) @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        idle(3);
        tests++;
        if (ov_cnt !== 0) begin fails++; $display("FAIL reset_idle_pulses: got %0d want 0", ov_cnt); end
    endtask

    task automatic test_ones();
        int base;
        fill_const(16'h0100, 16'h0100);
        compute_model();
        base = ov_cnt;
        ov_q.delete();
        drive_taps(0, TAPS - 1, 0);
        idle(4);
        tests++;
        if (ov_cnt - base !== 1) begin fails++; $display("FAIL ones_pulses: got %0d want 1", ov_cnt - base); end
        tests++;
        if (ov_cyc - last_tap_cyc !== 2) begin fails++; $display("FAIL ones_latency: got %0d want 2", ov_cyc - last_tap_cyc); end
        tests++;
        if (ov_q.size() == 0 || ov_q[0] !== exp_data) begin fails++; $display("FAIL ones_data: got %h want %h", out_data, exp_data); end
        tests++;
        if (out_data[(3*PAR+5)*BITS +: BITS] !== 16'h0900) begin
            fails++; $display("FAIL ones_lane: got %h want 0900", out_data[(3*PAR+5)*BITS +: BITS]);
        end
        tests++;
        if (out_data !== exp_data) begin fails++; $display("FAIL ones_hold: got %h want %h", out_data, exp_data); end
    endtask

    task automatic test_saturation();
        int base;
        fill_const(16'h7FFF, 16'h7FFF);
        compute_model();
        base = ov_cnt;
        drive_taps(0, TAPS - 1, 0);
        idle(4);
        tests++;
        if (ov_cnt - base !== 1 || out_data !== exp_data) begin
            fails++; $display("FAIL sat_pos: got %h want %h", out_data, exp_data);
        end
        fill_const(16'h7FFF, 16'h8001);
        compute_model();
        base = ov_cnt;
        drive_taps(0, TAPS - 1, 0);
        idle(4);
        tests++;
        if (ov_cnt - base !== 1 || out_data !== exp_data) begin
            fails++; $display("FAIL sat_neg: got %h want %h", out_data, exp_data);
        end
    endtask

    task automatic test_gaps();
        int base;
        logic [OUT_W-1:0] gapless;
        fill_random(1'b0);
        compute_model();
        drive_taps(0, TAPS - 1, 0);
        idle(4);
        gapless = out_data;
        tests++;
        if (gapless !== exp_data) begin fails++; $display("FAIL gapless_data: got %h want %h", gapless, exp_data); end
        base = ov_cnt;
        drive_taps(0, TAPS - 1, 3);
        idle(4);
        tests++;
        if (ov_cnt - base !== 1) begin fails++; $display("FAIL gaps_pulses: got %0d want 1", ov_cnt - base); end
        tests++;
        if (out_data !== exp_data) begin fails++; $display("FAIL gaps_data: got %h want %h", out_data, exp_data); end
    endtask

    task automatic test_clr();
        int base;
        fill_random(1'b0);
        base = ov_cnt;
        drive_taps(0, 4, 0);
        put_tap(5);
        clr = 1'b1;
        @(posedge clk_in);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        idle(4);
        tests++;
        if (ov_cnt - base !== 0) begin fails++; $display("FAIL clr_abort_pulses: got %0d want 0", ov_cnt - base); end
        fill_const(16'h0200, 16'h0080);
        compute_model();
        drive_taps(0, TAPS - 1, 0);
        idle(4);
        tests++;
        if (ov_cnt - base !== 1) begin fails++; $display("FAIL clr_fresh_pulses: got %0d want 1", ov_cnt - base); end
        tests++;
        if (out_data !== exp_data) begin fails++; $display("FAIL clr_fresh_data: got %h want %h", out_data, exp_data); end
        tests++;
        if (out_data[0 +: BITS] !== 16'h0900) begin fails++; $display("FAIL clr_lane0: got %h want 0900", out_data[0 +: BITS]); end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] exp_q[$];
        logic [OUT_W-1:0] got;
        ov_q.delete();
        for (int w = 0; w < 4; w++) begin
            fill_random(w[0]);
            compute_model();
            exp_q.push_back(exp_data);
            drive_taps(0, TAPS - 1, 0);
        end
        idle(4);
        tests++;
        if (ov_q.size() !== 4) begin fails++; $display("FAIL b2b_pulses: got %0d want 4", ov_q.size()); end
        for (int w = 0; w < 4; w++) begin
            tests++;
            if (ov_q.size() == 0) begin
                fails++; $display("FAIL b2b_data%0d: got none want %h", w, exp_q[w]);
            end else begin
                got = ov_q.pop_front();
                if (got !== exp_q[w]) begin fails++; $display("FAIL b2b_data%0d: got %h want %h", w, got, exp_q[w]); end
            end
        end
    endtask

    task automatic test_frame();
        int base;
        int fd_base;
        pulse_clr();
        base = ov_cnt;
        fd_base = fd_cnt;
        for (int round = 1; round <= 2; round++) begin
            for (int w = 0; w < WINS; w++) begin
                fill_random(1'b0);
                drive_taps(0, TAPS - 1, 0);
            end
            compute_model();
            idle(4);
            tests++;
            if (ov_cnt - base !== round * WINS) begin
                fails++; $display("FAIL frame%0d_pulses: got %0d want %0d", round, ov_cnt - base, round * WINS);
            end
            tests++;
            if (fd_cnt - fd_base !== round || fd_idx !== base + round * WINS) begin
                fails++; $display("FAIL frame%0d_done: got count %0d at %0d want %0d at %0d",
                                  round, fd_cnt - fd_base, fd_idx - base, round, round * WINS);
            end
            tests++;
            if (out_data !== exp_data) begin fails++; $display("FAIL frame%0d_data: got %h want %h", round, out_data, exp_data); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        fill_random(1'b0);
        drive_taps(0, 3, 0);
        put_tap(4);
        #2;
        rst_n = 1'b0;
        @(negedge clk_in);
        tests++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== '0) begin
            fails++; $display("FAIL midreset_outputs: got v=%b fd=%b d=%h want 0", out_valid, frame_done, out_data);
        end
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle(1);
        fill_random(1'b0);
        compute_model();
        base = ov_cnt;
        drive_taps(0, TAPS - 2, 0);
        idle(4);
        tests++;
        if (ov_cnt - base !== 0) begin fails++; $display("FAIL midreset_early: got %0d want 0", ov_cnt - base); end
        drive_taps(TAPS - 1, TAPS - 1, 0);
        idle(4);
        tests++;
        if (ov_cnt - base !== 1) begin fails++; $display("FAIL midreset_pulses: got %0d want 1", ov_cnt - base); end
        tests++;
        if (out_data !== exp_data) begin fails++; $display("FAIL midreset_data: got %h want %h", out_data, exp_data); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_saturation();
        test_gaps();
        test_clr();
        test_back_to_back();
        test_frame();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
